// File: rtl/knn_result_voter.sv
// knn_result_voter: tracks the nearest label in each dictionary group, votes it into per-class
// counters, and latches the majority class when knn_fin rises.
module knn_result_voter (
  input  logic        clk_en,
  input  logic        reset_n,
  input  logic        dic_go,
  input  logic [13:0] distance,
  input  logic [3:0]  m,
  input  logic        dic_end,
  input  logic        dic_end_q,
  input  logic        knn_fin,
  output logic        out_flag,
  output logic [3:0]  knn_resultf,
  output logic [13:0] min_o,
  output logic [3:0]  min_p_o,
  output logic [5:0]  max_o,
  output logic [3:0]  max_p_o,
  output logic [3:0]  max_cnt_o,
  output logic        q0_o,
  output logic        q1_o,
  output logic        fin_o,
  output logic        stop_o,
  output logic [5:0]  color_cnt_0,
  output logic [5:0]  color_cnt_1,
  output logic [5:0]  color_cnt_2,
  output logic [5:0]  color_cnt_3,
  output logic [5:0]  color_cnt_4
);
  logic [5:0] cnt [5];
  logic       fresh;
  logic [5:0] c_max;
  logic [3:0] c_idx;
  logic [3:0] c_ties;
  logic       accept;
  logic       vote;
  logic       finish;
  assign color_cnt_0 = cnt[0];
  assign color_cnt_1 = cnt[1];
  assign color_cnt_2 = cnt[2];
  assign color_cnt_3 = cnt[3];
  assign color_cnt_4 = cnt[4];
  assign accept = dic_go && !dic_end && !stop_o;
  assign vote   = dic_end && !q0_o && !stop_o;
  assign finish = knn_fin && !fin_o && !stop_o;
  // Strict compare keeps the lowest class index on ties.
  always_comb begin
    c_max  = '0;
    c_idx  = '0;
    c_ties = '0;
    for (int i = 0; i < 5; i++) begin
      c_idx = (cnt[i] > c_max) ? 4'(i) : c_idx;
      c_max = (cnt[i] > c_max) ? cnt[i] : c_max;
    end
    for (int i = 0; i < 5; i++) c_ties = (cnt[i] == c_max) ? c_ties + 4'd1 : c_ties;
  end
  always_ff @(posedge clk_en) begin
    if (reset_n) begin
      out_flag    <= 1'b0;
      knn_resultf <= '0;
      min_o       <= '0;
      min_p_o     <= '0;
      max_o       <= '0;
      max_p_o     <= '0;
      max_cnt_o   <= '0;
      q0_o        <= 1'b0;
      q1_o        <= 1'b0;
      fin_o       <= 1'b0;
      stop_o      <= 1'b0;
      fresh       <= 1'b1;
      for (int i = 0; i < 5; i++) cnt[i] <= '0;
    end else begin
      q0_o      <= dic_end;
      q1_o      <= dic_end_q;
      fin_o     <= knn_fin;
      max_o     <= c_max;
      max_p_o   <= c_idx;
      max_cnt_o <= c_ties;
      out_flag  <= finish;
      if (finish) begin
        knn_resultf <= c_idx;
        stop_o      <= 1'b1;
      end
      if (accept && (fresh || dic_end_q || distance < min_o)) begin
        min_o   <= distance;
        min_p_o <= m;
      end
      if (accept) fresh <= 1'b0;
      if (vote) fresh <= 1'b1;
      for (int i = 0; i < 5; i++)
        if (vote && min_p_o == 4'(i) && cnt[i] != 6'd63) cnt[i] <= cnt[i] + 6'd1;
    end
  end
endmodule

// File: tb/tb_knn_result_voter.sv
// tb_knn_result_voter: randomized groups checked against a per-group nearest-label vote model.
module tb_knn_result_voter;
  logic        clk_en = 0, reset_n = 0, dic_go = 0, dic_end = 0, dic_end_q = 0, knn_fin = 0;
  logic [13:0] distance = 0;
  logic [3:0]  m = 0;
  logic        out_flag, q0_o, q1_o, fin_o, stop_o;
  logic [3:0]  knn_resultf, min_p_o, max_p_o, max_cnt_o;
  logic [13:0] min_o;
  logic [5:0]  max_o, color_cnt_0, color_cnt_1, color_cnt_2, color_cnt_3, color_cnt_4;
  logic [5:0]  cc [5];
  int exp_cnt [5];
  int exp_min, exp_minp, exp_res;
  bit exp_stop;
  int n_cmp = 0, n_fail = 0;

  knn_result_voter dut (
    .clk_en(clk_en), .reset_n(reset_n), .dic_go(dic_go), .distance(distance), .m(m),
    .dic_end(dic_end), .dic_end_q(dic_end_q), .knn_fin(knn_fin), .out_flag(out_flag),
    .knn_resultf(knn_resultf), .min_o(min_o), .min_p_o(min_p_o), .max_o(max_o),
    .max_p_o(max_p_o), .max_cnt_o(max_cnt_o), .q0_o(q0_o), .q1_o(q1_o), .fin_o(fin_o),
    .stop_o(stop_o), .color_cnt_0(color_cnt_0), .color_cnt_1(color_cnt_1),
    .color_cnt_2(color_cnt_2), .color_cnt_3(color_cnt_3), .color_cnt_4(color_cnt_4)
  );

  assign cc[0] = color_cnt_0;
  assign cc[1] = color_cnt_1;
  assign cc[2] = color_cnt_2;
  assign cc[3] = color_cnt_3;
  assign cc[4] = color_cnt_4;

  always #5 clk_en = ~clk_en;

  task automatic tick;
    @(posedge clk_en);
    #1;
  endtask

  function automatic int argmax_ref();
    int best = 0;
    for (int i = 1; i < 5; i++) if (exp_cnt[i] > exp_cnt[best]) best = i;
    return best;
  endfunction

  task automatic do_reset;
    reset_n = 1; dic_go = 0; dic_end = 0; dic_end_q = 0; knn_fin = 0;
    tick; tick;
    reset_n = 0;
    for (int i = 0; i < 5; i++) exp_cnt[i] = 0;
    exp_min = 0; exp_minp = 0; exp_res = 0; exp_stop = 0;
    tick;
  endtask

  // One group: the first sample opens the group, dic_end is held two cycles.
  task automatic do_group(input int n, input int lab);
    int d, l;
    for (int i = 0; i < n; i++) begin
      d = int'($urandom % 1024);
      l = (lab < 0) ? int'($urandom_range(0, 4)) : lab;
      dic_go = 1; distance = 14'(d); m = 4'(l); dic_end_q = (i == 0);
      if (!exp_stop && (i == 0 || d < exp_min)) begin exp_min = d; exp_minp = l; end
      tick;
    end
    dic_go = 0; dic_end_q = 0;
    n_cmp++;
    if (min_o !== 14'(exp_min) || min_p_o !== 4'(exp_minp)) begin
      n_fail++;
      $display("FAIL group_min: got %0d/%0d expected %0d/%0d", min_o, min_p_o, exp_min, exp_minp);
    end
    dic_end = 1; tick; tick;
    dic_end = 0; tick;
    if (!exp_stop && exp_minp <= 4 && exp_cnt[exp_minp] < 63) exp_cnt[exp_minp]++;
  endtask

  task automatic do_finish;
    knn_fin = 1; tick;
    if (!exp_stop) begin exp_res = argmax_ref(); exp_stop = 1; end
  endtask

  task automatic test_reset;
    reset_n = 1; dic_go = 1; distance = 77; m = 2; knn_fin = 1; dic_end = 1;
    tick; tick;
    n_cmp++;
    if ({out_flag, knn_resultf, min_o, min_p_o, max_o, max_p_o, max_cnt_o, q0_o, q1_o, fin_o,
         stop_o, color_cnt_0, color_cnt_1, color_cnt_2, color_cnt_3, color_cnt_4} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got nonzero min_o=%0d max_cnt_o=%0d stop_o=%0d expected all 0",
               min_o, max_cnt_o, stop_o);
    end
    reset_n = 0; dic_go = 0; knn_fin = 0; dic_end = 0;
    tick;
    n_cmp++;
    if (max_cnt_o !== 4'd5 || max_o !== 6'd0 || max_p_o !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_live_max: got %0d/%0d/%0d expected 0/0/5", max_o, max_p_o, max_cnt_o);
    end
  endtask

  task automatic test_single_group;
    int ds [5] = '{500, 120, 800, 120, 900};
    do_reset;
    for (int i = 0; i < 5; i++) begin
      dic_go = 1; distance = 14'(ds[i]); m = 4'(i); dic_end_q = 0;
      tick;
    end
    dic_go = 0;
    n_cmp++;
    if (min_o !== 14'd120 || min_p_o !== 4'd1) begin
      n_fail++;
      $display("FAIL single_min: got %0d/%0d expected 120/1", min_o, min_p_o);
    end
    dic_end = 1; tick; tick;
    dic_end = 0; tick;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (cc[i] !== 6'((i == 1) ? 1 : 0)) begin
        n_fail++;
        $display("FAIL single_cnt%0d: got %0d expected %0d", i, cc[i], (i == 1) ? 1 : 0);
      end
    end
    n_cmp++;
    if (max_o !== 6'd1 || max_p_o !== 4'd1 || max_cnt_o !== 4'd1) begin
      n_fail++;
      $display("FAIL single_max: got %0d/%0d/%0d expected 1/1/1", max_o, max_p_o, max_cnt_o);
    end
  endtask

  task automatic test_random_groups;
    int sum;
    do_reset;
    for (int g = 0; g < 16; g++) do_group(int'($urandom_range(1, 4)), -1);
    sum = 0;
    for (int i = 0; i < 5; i++) begin
      sum += int'(cc[i]);
      n_cmp++;
      if (cc[i] !== 6'(exp_cnt[i])) begin
        n_fail++;
        $display("FAIL random_cnt%0d: got %0d expected %0d", i, cc[i], exp_cnt[i]);
      end
    end
    n_cmp++;
    if (sum != 16) begin
      n_fail++;
      $display("FAIL random_sum: got %0d expected 16", sum);
    end
    do_finish;
    n_cmp++;
    if (out_flag !== 1'b1 || stop_o !== 1'b1 || knn_resultf !== 4'(exp_res) || knn_resultf !== max_p_o) begin
      n_fail++;
      $display("FAIL random_finish: got flag=%0d stop=%0d res=%0d maxp=%0d expected 1/1/%0d",
               out_flag, stop_o, knn_resultf, max_p_o, exp_res);
    end
    tick;
    knn_fin = 0;
    n_cmp++;
    if (out_flag !== 1'b0 || stop_o !== 1'b1) begin
      n_fail++;
      $display("FAIL random_flag_pulse: got flag=%0d stop=%0d expected 0/1", out_flag, stop_o);
    end
  endtask

  task automatic test_tie;
    do_reset;
    for (int g = 0; g < 3; g++) do_group(2, 0);
    for (int g = 0; g < 3; g++) do_group(2, 1);
    do_finish;
    knn_fin = 0; tick;
    n_cmp++;
    if (knn_resultf !== 4'(exp_res) || max_o !== 6'd3 || max_cnt_o !== 4'd2 || exp_res != 0) begin
      n_fail++;
      $display("FAIL tie: got res=%0d max=%0d cnt=%0d expected %0d/3/2", knn_resultf, max_o, max_cnt_o, exp_res);
    end
  endtask

  task automatic test_after_stop;
    for (int g = 0; g < 4; g++) do_group(3, -1);
    knn_fin = 1;
    for (int c = 0; c < 3; c++) begin
      tick;
      n_cmp++;
      if (out_flag !== 1'b0 || stop_o !== 1'b1 || knn_resultf !== 4'(exp_res)) begin
        n_fail++;
        $display("FAIL stop_hold: got flag=%0d stop=%0d res=%0d expected 0/1/%0d", out_flag, stop_o, knn_resultf, exp_res);
      end
    end
    knn_fin = 0; tick;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (cc[i] !== 6'(exp_cnt[i])) begin
        n_fail++;
        $display("FAIL stop_cnt%0d: got %0d expected %0d", i, cc[i], exp_cnt[i]);
      end
    end
  endtask

  task automatic test_saturation;
    do_reset;
    for (int g = 0; g < 70; g++) do_group(1, 2);
    do_group(3, 9);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (cc[i] !== 6'(exp_cnt[i]) || exp_cnt[2] != 63) begin
        n_fail++;
        $display("FAIL sat_cnt%0d: got %0d expected %0d", i, cc[i], exp_cnt[i]);
      end
    end
  endtask

  // Vote and finish edge together: vote lands, result uses the pre-vote counts.
  task automatic test_back_to_back;
    do_reset;
    do_group(2, 0);
    do_group(2, 3);
    dic_go = 1; distance = 5; m = 3; dic_end_q = 1; tick;
    dic_go = 0; dic_end_q = 0;
    dic_end = 1; knn_fin = 1; tick;
    exp_res = argmax_ref();
    exp_cnt[3]++;
    exp_stop = 1;
    n_cmp++;
    if (out_flag !== 1'b1 || knn_resultf !== 4'(exp_res) || cc[3] !== 6'(exp_cnt[3])) begin
      n_fail++;
      $display("FAIL same_edge: got flag=%0d res=%0d cnt3=%0d expected 1/%0d/%0d",
               out_flag, knn_resultf, cc[3], exp_res, exp_cnt[3]);
    end
    dic_end = 0; knn_fin = 0; tick;
    n_cmp++;
    if (max_p_o !== 4'd3 || max_o !== 6'd2 || max_cnt_o !== 4'd1 || q0_o !== 1'b0 || fin_o !== 1'b0) begin
      n_fail++;
      $display("FAIL same_edge_live: got %0d/%0d/%0d q0=%0d fin=%0d expected 2/3/1 0 0",
               max_o, max_p_o, max_cnt_o, q0_o, fin_o);
    end
  endtask

  initial begin
    test_reset;
    test_single_group;
    test_random_groups;
    test_tie;
    test_after_stop;
    test_saturation;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/knn_result_voter.md
# knn_result_voter

Final decision stage of the KNN accelerator (DUT module `knn_result`). It receives one (distance, label) pair per cycle from the distance engine and finds the nearest label within each dictionary group. It casts one vote per group into five per-class counters. On `knn_fin` it latches the majority class as the classification result.

## Interface
Parameters: none. Fixed values: 5 classes (labels 0–4), 14-bit distances, 6-bit vote counters.

- `clk_en`  in  1  sole clock; all state updates on its rising edge
- `reset_n`  in  1  reset, synchronous, active-high (1 = reset, despite the name)
- `dic_go`  in  1  sample enable; distances accepted only while 1
- `distance`  in  14  distance of current candidate
- `m`  in  4  class label of current candidate
- `dic_end`  in  1  end of a dictionary group (level, may span several cycles)
- `dic_end_q`  in  1  delayed group-end marker; 1 means the next accepted sample opens a new group
- `knn_fin`  in  1  all groups done; rising edge requests the result
- `out_flag`  out  1  one-cycle pulse when `knn_resultf` becomes valid
- `knn_resultf`  out  4  latched winning class
- `min_o`  out  14  running minimum distance of current group
- `min_p_o`  out  4  label of that minimum
- `max_o`  out  6  largest vote count (live)
- `max_p_o`  out  4  class holding `max_o` (live)
- `max_cnt_o`  out  4  number of classes tied at `max_o` (live)
- `q0_o`  out  1  `dic_end` registered one cycle
- `q1_o`  out  1  `dic_end_q` registered one cycle
- `fin_o`  out  1  `knn_fin` registered one cycle
- `stop_o`  out  1  sticky; result produced, block frozen
- `color_cnt_0..4`  out  6 each  vote counters for classes 0–4

## Operation
- Reset: all outputs and registers 0. The internal `fresh` flag is set to 1.
- Accepted sample: `dic_go`=1, `dic_end`=0 and `stop_o`=0.
  - If `fresh`=1 or `dic_end_q`=1: load `min_o`←`distance` and `min_p_o`←`m`, then clear `fresh`.
  - Otherwise, if `distance` < `min_o` (strict, unsigned): update both. Ties keep the earlier sample.
- Vote: on the first cycle of `dic_end`, i.e. `dic_end`=1 and `q0_o`=0, with `stop_o`=0.
  - If `min_p_o` ≤ 4, increment `color_cnt_[min_p_o]`. Counters saturate at 63.
  - Labels 5–15 cast no vote.
  - Set `fresh`=1.
  - A second consecutive `dic_end` cycle does nothing.
- Live argmax, registered every cycle from the current counters:
  - `max_o` = maximum count.
  - `max_p_o` = lowest class index with that count.
  - `max_cnt_o` = number of classes equal to the maximum. All-zero counters give 0/0/5.
- Finish: when `knn_fin`=1, `fin_o`=0 and `stop_o`=0:
  - `knn_resultf` ← argmax computed combinationally from the current counters, lowest index on ties.
  - `out_flag` ← 1 for exactly one cycle.
  - `stop_o` ← 1.
- While `stop_o`=1:
  - Samples, votes and further `knn_fin` edges are ignored.
  - Counters, min and result hold.
  - `q0_o`, `q1_o`, `fin_o` and the live max outputs keep updating.
- Reset at any time, including mid-group or after stop, returns to the reset state on that edge.

## Timing
- Sample to `min_o`/`min_p_o`: 1 cycle.
- `dic_end` rise to counter increment: 1 cycle.
- Counter change to `max_o`/`max_p_o`/`max_cnt_o`: 1 further cycle.
- `knn_fin` rise to `knn_resultf`/`out_flag`/`stop_o`: 1 cycle.
  - The result includes a vote registered on the same edge only if that vote occurred before `knn_fin` rose.
  - Simultaneous vote and finish edge: the vote is committed, but the result is taken from the pre-vote counters.
- `q0_o`, `q1_o`, `fin_o`: plain 1-cycle delays, not gated by `stop_o`.
- `dic_go`=0 freezes min tracking only. Votes and finish still operate.

## Test plan
- Reset: hold `reset_n`=1 for 2 cycles → every output 0, `max_cnt_o`=5 one cycle after release.
- Single group, labels 0..4 with distances 500, 120, 800, 120, 900 → `min_o`=120 and `min_p_o`=1. Then pulse `dic_end` for 2 cycles → `color_cnt_1`=1 and all others 0.
- 16 groups with random distances (mod 1024) → counters sum to 16. After `knn_fin`: `knn_resultf`=`max_p_o`, `out_flag` high exactly 1 cycle, `stop_o`=1.
- Tie: votes 3,3,0,0,0 → `knn_resultf`=0, `max_o`=3, `max_cnt_o`=2.
- After stop: further groups and a second `knn_fin` pulse → counters, `knn_resultf` and `out_flag`=0 unchanged.
- Saturation and invalid label: 70 groups all won by class 2 → `color_cnt_2`=63. A group whose minimum carries label 9 → no counter changes.
